// File: rtl/wb_pkg.sv
// wb_pkg: shared constants for the write-back stage.
//   - XLEN_DEFAULT : datapath width (only 32 is supported)
//   - WB_SEL_*     : write-back source select codes
//   - F3_*         : load funct3 width/sign codes
package wb_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;
   localparam logic [1:0] WB_SEL_IMM = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extender.sv
// load_extender: combinational load-data lane extraction and extension.
// Ports:
//   rdata      in  XLEN  aligned data-memory word
//   addr_lo    in  2     byte offset of the load address
//   funct3     in  3     load width/sign code
//   data       out XLEN  extracted and extended load value
//   misaligned out 1     halfword on odd offset, or word on nonzero offset
// Reserved funct3 codes (011/110/111) pass the raw word and never fault.
module load_extender
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            misaligned
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Low bits of (rdata >> 8*addr_lo); the shift zero-fills from the top,
   // so the offset-3 halfword only has one real byte.
   always_comb begin
      byte_lane = rdata[7:0];
      half_lane = rdata[15:0];
      case (addr_lo)
         2'd0: begin byte_lane = rdata[7:0];   half_lane = rdata[15:0];          end
         2'd1: begin byte_lane = rdata[15:8];  half_lane = rdata[23:8];          end
         2'd2: begin byte_lane = rdata[23:16]; half_lane = rdata[31:16];         end
         default: begin byte_lane = rdata[31:24]; half_lane = {8'h00, rdata[31:24]}; end
      endcase
   end

   always_comb begin
      data       = rdata;
      misaligned = 1'b0;
      case (funct3)
         F3_LB:  data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
         F3_LBU: data = {{(XLEN-8){1'b0}}, byte_lane};
         F3_LH: begin
            data       = {{(XLEN-16){half_lane[15]}}, half_lane};
            misaligned = addr_lo[0];
         end
         F3_LHU: begin
            data       = {{(XLEN-16){1'b0}}, half_lane};
            misaligned = addr_lo[0];
         end
         F3_LW: begin
            data       = rdata;
            misaligned = (addr_lo != 2'b00);
         end
         default: begin
            data       = rdata;
            misaligned = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register plus write-back source mux
// feeding the RegisterFile write port directly.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   stall, flush        hold contents / load a bubble (flush wins)
//   in_*                instruction fields from the MEM stage
//   rd, write_data,     registered RegisterFile write port
//   reg_write
//   wb_valid            stage holds a valid instruction
//   misaligned          registered misaligned-load flag
//   retired_count       64-bit retired-instruction counter, present only
//                       when WB_RETIRE_COUNT_EN is defined
// Writes to x0 and misaligned loads never assert reg_write.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [4:0]      in_rd,
   input  logic            in_reg_write,
   input  logic [1:0]      in_wb_sel,
   input  logic [2:0]      in_funct3,
   input  logic [1:0]      in_addr_lo,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_mem_rdata,
   input  logic [XLEN-1:0] in_pc_plus4,
   input  logic [XLEN-1:0] in_imm,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] write_data,
   output logic            reg_write,
   output logic            wb_valid,
   output logic            misaligned
`ifdef WB_RETIRE_COUNT_EN
   ,
   output logic [63:0]     retired_count
`endif
);

   logic [XLEN-1:0] load_data;
   logic            load_misaligned;
   logic            is_load;
   logic            fault_next;
   logic [XLEN-1:0] write_data_next;
   logic            reg_write_next;

   logic [4:0]      rd_reg;
   logic [XLEN-1:0] write_data_reg;
   logic            reg_write_reg;
   logic            wb_valid_reg;
   logic            misaligned_reg;

   load_extender #(.XLEN(XLEN)) u_load_extender (
      .rdata      (in_mem_rdata),
      .addr_lo    (in_addr_lo),
      .funct3     (in_funct3),
      .data       (load_data),
      .misaligned (load_misaligned)
   );

   // The extender's fault only matters for instructions that are loads.
   assign is_load    = (in_wb_sel == WB_SEL_MEM);
   assign fault_next = is_load & load_misaligned;

   always_comb begin
      write_data_next = in_alu_result;
      case (in_wb_sel)
         WB_SEL_ALU: write_data_next = in_alu_result;
         WB_SEL_MEM: write_data_next = load_data;
         WB_SEL_PC4: write_data_next = in_pc_plus4;
         default:    write_data_next = in_imm;
      endcase
   end

   assign reg_write_next = in_valid & in_reg_write & (in_rd != 5'd0) & ~fault_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_reg         <= '0;
         write_data_reg <= '0;
         reg_write_reg  <= 1'b0;
         wb_valid_reg   <= 1'b0;
         misaligned_reg <= 1'b0;
      end else if (flush) begin
         rd_reg         <= '0;
         write_data_reg <= '0;
         reg_write_reg  <= 1'b0;
         wb_valid_reg   <= 1'b0;
         misaligned_reg <= 1'b0;
      end else if (!stall) begin
         // write_data and rd are captured even for non-writing entries so
         // the last value stays visible when debugging.
         rd_reg         <= in_rd;
         write_data_reg <= write_data_next;
         reg_write_reg  <= reg_write_next;
         wb_valid_reg   <= in_valid;
         misaligned_reg <= in_valid & fault_next;
      end
   end

   assign rd         = rd_reg;
   assign write_data = write_data_reg;
   assign reg_write  = reg_write_reg;
   assign wb_valid   = wb_valid_reg;
   assign misaligned = misaligned_reg;

`ifdef WB_RETIRE_COUNT_EN
   logic [63:0] retired_count_reg;

   // Counts every valid entry loaded, including faulting or non-writing
   // ones; natural 64-bit wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired_count_reg <= '0;
      end else if (!flush && !stall && in_valid) begin
         retired_count_reg <= retired_count_reg + 64'd1;
      end
   end

   assign retired_count = retired_count_reg;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush, in_valid, in_reg_write;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel, in_addr_lo;
   logic [2:0]  in_funct3;
   logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;
   logic [4:0]  rd;
   logic [31:0] write_data;
   logic        reg_write, wb_valid, misaligned;
`ifdef WB_RETIRE_COUNT_EN
   logic [63:0] retired_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   writeback_stage #(.XLEN(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_rd         (in_rd),
      .in_reg_write  (in_reg_write),
      .in_wb_sel     (in_wb_sel),
      .in_funct3     (in_funct3),
      .in_addr_lo    (in_addr_lo),
      .in_alu_result (in_alu_result),
      .in_mem_rdata  (in_mem_rdata),
      .in_pc_plus4   (in_pc_plus4),
      .in_imm        (in_imm),
      .rd            (rd),
      .write_data    (write_data),
      .reg_write     (reg_write),
      .wb_valid      (wb_valid),
      .misaligned    (misaligned)
`ifdef WB_RETIRE_COUNT_EN
      ,
      .retired_count (retired_count)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check the full output set of the stage in one line.
   task automatic chk_all(input string tag, input logic [4:0] e_rd, input logic [31:0] e_wd,
                          input logic e_rw, input logic e_v, input logic e_mis);
      chk({tag, ".rd"}, 64'(rd), 64'(e_rd));
      chk({tag, ".wdata"}, 64'(write_data), 64'(e_wd));
      chk({tag, ".reg_write"}, 64'(reg_write), 64'(e_rw));
      chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(e_v));
      chk({tag, ".misaligned"}, 64'(misaligned), 64'(e_mis));
      $display("txn %-12s rd=%0d wdata=%h rw=%b v=%b mis=%b", tag, rd, write_data,
               reg_write, wb_valid, misaligned);
   endtask

   task automatic drive(input logic v, input logic [4:0] r, input logic rw, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] alu);
      in_valid      = v;
      in_rd         = r;
      in_reg_write  = rw;
      in_wb_sel     = sel;
      in_funct3     = f3;
      in_addr_lo    = alo;
      in_alu_result = alu;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b0, 5'd0, 1'b0, WB_SEL_ALU, F3_LB, 2'd0, 32'h0);
      in_mem_rdata = 32'h80F1_7F82;
      in_pc_plus4  = 32'h0000_1004;
      in_imm       = 32'hDEAD_B000;
      tick(); tick();
      chk_all("reset", 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // ALU write
      drive(1'b1, 5'd3, 1'b1, WB_SEL_ALU, F3_LB, 2'd0, 32'hABCD_1234);
      tick();
      chk_all("alu", 5'd3, 32'hABCD_1234, 1'b1, 1'b1, 1'b0);

      // Load extraction on 80F17F82
      drive(1'b1, 5'd4, 1'b1, WB_SEL_MEM, F3_LB, 2'd0, 32'h0);  tick();
      chk_all("lb0", 5'd4, 32'hFFFF_FF82, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd4, 1'b1, WB_SEL_MEM, F3_LB, 2'd1, 32'h0);  tick();
      chk_all("lb1", 5'd4, 32'h0000_007F, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd4, 1'b1, WB_SEL_MEM, F3_LBU, 2'd3, 32'h0); tick();
      chk_all("lbu3", 5'd4, 32'h0000_0080, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd4, 1'b1, WB_SEL_MEM, F3_LH, 2'd2, 32'h0);  tick();
      chk_all("lh2", 5'd4, 32'hFFFF_80F1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd4, 1'b1, WB_SEL_MEM, F3_LHU, 2'd0, 32'h0); tick();
      chk_all("lhu0", 5'd4, 32'h0000_7F82, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd4, 1'b1, WB_SEL_MEM, F3_LW, 2'd0, 32'h0);  tick();
      chk_all("lw0", 5'd4, 32'h80F1_7F82, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd4, 1'b1, WB_SEL_MEM, 3'b011, 2'd3, 32'h0); tick();
      chk_all("f3_011", 5'd4, 32'h80F1_7F82, 1'b1, 1'b1, 1'b0);

      // Misaligned loads: lane for lh @1 is F17F -> FFFFF17F
      drive(1'b1, 5'd6, 1'b1, WB_SEL_MEM, F3_LH, 2'd1, 32'h0);  tick();
      chk_all("lh1_mis", 5'd6, 32'hFFFF_F17F, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 5'd6, 1'b1, WB_SEL_MEM, F3_LW, 2'd2, 32'h0);  tick();
      chk_all("lw2_mis", 5'd6, 32'h80F1_7F82, 1'b0, 1'b1, 1'b1);
      // Same funct3/addr on a non-load must not fault
      drive(1'b1, 5'd6, 1'b1, WB_SEL_ALU, F3_LH, 2'd1, 32'h55);  tick();
      chk_all("alu_nomis", 5'd6, 32'h0000_0055, 1'b1, 1'b1, 1'b0);

      // x0, PC+4, IMM, invalid
      drive(1'b1, 5'd0, 1'b1, WB_SEL_ALU, F3_LB, 2'd0, 32'h77);  tick();
      chk_all("x0", 5'd0, 32'h0000_0077, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 5'd1, 1'b1, WB_SEL_PC4, F3_LB, 2'd0, 32'h0);   tick();
      chk_all("pc4", 5'd1, 32'h0000_1004, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd7, 1'b1, WB_SEL_IMM, F3_LB, 2'd0, 32'h0);   tick();
      chk_all("imm", 5'd7, 32'hDEAD_B000, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 5'd7, 1'b1, WB_SEL_IMM, F3_LB, 2'd0, 32'h0);   tick();
      chk_all("bubble", 5'd7, 32'hDEAD_B000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd8, 1'b0, WB_SEL_ALU, F3_LB, 2'd0, 32'h99);  tick();
      chk_all("no_rw", 5'd8, 32'h0000_0099, 1'b0, 1'b1, 1'b0);

      // Stall holds for 3 cycles with changing inputs
      drive(1'b1, 5'd5, 1'b1, WB_SEL_ALU, F3_LB, 2'd0, 32'h11);  tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'(9 + i), 1'b1, WB_SEL_ALU, F3_LB, 2'd0, 32'(32'h100 + i));
         tick();
         chk_all("stall", 5'd5, 32'h11, 1'b1, 1'b1, 1'b0);
      end
      flush = 1'b1; tick();
      chk_all("flush_stall", 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
      flush = 1'b0; stall = 1'b0;

      // Misaligned flag held across stall, cleared by flush
      drive(1'b1, 5'd6, 1'b1, WB_SEL_MEM, F3_LHU, 2'd3, 32'h0); tick();
      chk_all("lhu3_mis", 5'd6, 32'h0000_0080, 1'b0, 1'b1, 1'b1);
      stall = 1'b1;
      drive(1'b1, 5'd2, 1'b1, WB_SEL_ALU, F3_LB, 2'd0, 32'h3);   tick();
      chk_all("mis_stall", 5'd6, 32'h0000_0080, 1'b0, 1'b1, 1'b1);
      stall = 1'b0; flush = 1'b1; tick();
      chk_all("mis_flush", 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
      flush = 1'b0;

      // Asynchronous reset mid-operation and mid-stall
      drive(1'b1, 5'd3, 1'b1, WB_SEL_ALU, F3_LB, 2'd0, 32'hCAFE_0001); tick();
      chk_all("pre_reset", 5'd3, 32'hCAFE_0001, 1'b1, 1'b1, 1'b0);
      stall = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk_all("async_rst", 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b0; stall = 1'b0;
      tick();
      chk_all("post_reset", 5'd3, 32'hCAFE_0001, 1'b1, 1'b1, 1'b0);

`ifdef WB_RETIRE_COUNT_EN
      reset = 1'b1; #1; reset = 1'b0;
      chk("cnt_reset", retired_count, 64'd0);
      drive(1'b1, 5'd3, 1'b1, WB_SEL_ALU, F3_LB, 2'd0, 32'h1);
      for (int i = 0; i < 3; i++) tick();
      drive(1'b1, 5'd3, 1'b1, WB_SEL_MEM, F3_LW, 2'd1, 32'h1);  // misaligned still counts
      tick();
      stall = 1'b1; tick(); tick(); stall = 1'b0;
      flush = 1'b1; tick(); flush = 1'b0;
      in_valid = 1'b0; tick();
      chk("cnt_four", retired_count, 64'd4);
      $display("txn retired_count=%0d", retired_count);
      force dut.retired_count_reg = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.retired_count_reg;
      chk("cnt_preload", retired_count, 64'hFFFF_FFFF_FFFF_FFFF);
      in_valid = 1'b1; tick();
      chk("cnt_wrap", retired_count, 64'd0);
      $display("txn retired_count=%0d", retired_count);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back mux that directly feeds the RegisterFile write port (rd, write_data, reg_write).
- Selects ALU result, load data, PC+4 or immediate (LUI), and performs load byte/half extraction with sign/zero extension.
- Suppresses writes to x0 and to misaligned loads.
- Single-cycle latency; supports stall and flush from the hazard unit.

Parameters:
XLEN, 32, datapath width (only 32 supported).

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold current stage contents
flush  in  1  load a bubble; takes priority over stall
in_valid  in  1  an instruction is present at the stage input
in_rd  in  5  destination register
in_reg_write  in  1  instruction writes rd
in_wb_sel  in  2  source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM
in_funct3  in  3  load width/sign code (used only when wb_sel=01)
in_addr_lo  in  2  ALU address bits [1:0] for the load
in_alu_result  in  XLEN  ALU output
in_mem_rdata  in  XLEN  aligned data-memory word
in_pc_plus4  in  XLEN  link value
in_imm  in  XLEN  U-type immediate
rd  out  5  to RegisterFile rd
write_data  out  XLEN  to RegisterFile write_data
reg_write  out  1  to RegisterFile reg_write
wb_valid  out  1  stage holds a valid instruction
misaligned  out  1  registered flag for a misaligned load in the stage

Behaviour:
- Reset (asynchronous, any time, including mid-stall): rd=0, write_data=0, reg_write=0, wb_valid=0, misaligned=0.
- Each posedge, in priority order:
  - flush: load a bubble, with all outputs 0 (same as the reset values).
  - else stall: all outputs hold their values.
  - else load the input. Outputs reflect inputs sampled at edge k immediately after edge k; RegisterFile commits at edge k+1.
- Load extraction (wb_sel=01):
  - lane = in_mem_rdata >> (8*in_addr_lo).
  - funct3 000 lb: sign-extend lane[7:0]. 100 lbu: zero-extend lane[7:0].
  - 001 lh: sign-extend lane[15:0]. 101 lhu: zero-extend lane[15:0].
  - 010 lw: the full word.
  - 011/110/111: write_data = in_mem_rdata, no fault.
- Misaligned = wb_sel=01 and either:
  - (funct3 in {001,101} and addr_lo[0]=1), or
  - (funct3=010 and addr_lo≠00).
- reg_write = in_valid & in_reg_write & (in_rd≠0) & ~misaligned.
- write_data is still registered when reg_write=0 (debug visibility). rd is always registered as given.
- misaligned output = in_valid & misaligned condition. It stays high across a stall and is cleared by flush.
- wb_sel=11 passes in_imm unchanged; 10 passes in_pc_plus4 unchanged. No arithmetic is performed in this stage.
- During stall, reg_write held high rewrites the identical value into the RegisterFile; this is idempotent and allowed.
- flush and stall asserted together: flush wins.
- in_valid=0 with no stall/flush: the stage becomes a bubble (wb_valid=0, reg_write=0).

Optional Feature:
WB_RETIRE_COUNT_EN
- Defined: adds output retired_count, 64 bits, reset 0.
  - Increments by 1 on each posedge where the stage loads an entry with in_valid=1 (not stall, not flush), including misaligned or non-writing instructions.
  - Wraps from 2^64-1 to 0.
  - Held during stall; unaffected by flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package wb_pkg: WB_SEL_ALU/MEM/PC4/IMM codes; F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU constants; XLEN default.
- One combinational sub-module, load_extender: inputs rdata, addr_lo, funct3; outputs data and misaligned. Keeps the stage register logic flat.

Test Plan:
- Reset mid-operation: assert reset with wb_valid=1 -> all outputs 0 immediately, before the next clk edge.
- ALU write: wb_sel=00, alu_result=32'hABCD1234, rd=3, reg_write=1 -> after one edge rd=3, write_data=ABCD1234, reg_write=1. A RegisterFile read of x3 returns ABCD1234 on the following cycle.
- Load extension, mem_rdata=32'h80F1_7F82:
  - lb addr_lo=0 -> FFFFFF82
  - lbu addr_lo=3 -> 00000080
  - lh addr_lo=2 -> FFFF80F1
  - lhu addr_lo=0 -> 00007F82
  - lw addr_lo=0 -> 80F17F82
- Misaligned/x0: lh addr_lo=1 -> misaligned=1, reg_write=0. lw addr_lo=2 -> misaligned=1. Valid write to rd=0 -> reg_write=0, rd=0.
- Stall/flush: load an entry (rd=5, alu_result=0x11), then stall 3 cycles with changing inputs -> outputs hold rd=5, write_data=0x11. Assert flush+stall -> bubble, wb_valid=0.
- WB_RETIRE_COUNT_EN defined: 4 valid loads, 2 stalled cycles, 1 flush, 1 in_valid=0 -> retired_count=4. Preload 2^64-1 via 2^64-1 loads (or force) -> next valid load wraps to 0.
